// File: rtl/ext_mem_pkg.sv
// Shared types and helpers for the external-memory responder.
package ext_mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DM_ACC = 2'd1,
      ST_PM_ACC = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   // FSM register; last_dm records which side the DONE cycle belongs to.
   typedef struct packed {
      state_t state;
      logic   last_dm;
   } fsm_t;

   localparam int          EXT_MSB_HI   = 15;
   localparam int          EXT_MSB_LO   = 12;
   localparam logic [15:0] TIMEOUT_DATA = 16'hFFFF;

   // An address is external when any bit of the top nibble is set.
   function automatic logic is_ext(input logic [15:0] addr);
      return |addr[EXT_MSB_HI:EXT_MSB_LO];
   endfunction

endpackage

// File: rtl/ext_mem_responder_wait_state_counter.sv
// Saturating wait-state counter for one external access.
module wait_state_counter
   import ext_mem_pkg::*;
#(
   parameter int WAIT_CYCLES = 3,
   parameter int MAX_WAIT    = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic min_reached,
   output logic expired
);

   localparam int            CW     = $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0] WAIT_V = CW'(WAIT_CYCLES);
   localparam logic [CW-1:0] MAX_V  = CW'(MAX_WAIT);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Clear wins over count; counting stops at MAX_WAIT.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && (cnt_q != MAX_V)) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign min_reached = (cnt_q >= WAIT_V);
   assign expired     = (cnt_q == MAX_V);

endmodule

// File: rtl/ext_mem_responder.sv
// Runs external PM/DM bus accesses with wait states and holds the pipeline
// (stall low) until each access completes. Data side wins arbitration.
module ext_mem_responder
   import ext_mem_pkg::*;
#(
   parameter int WAIT_CYCLES = 3,
   parameter int MAX_WAIT    = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pm_req,
   input  logic [15:0] pm_add,
   input  logic        dm_req,
   input  logic [15:0] dm_add,
   input  logic        rwb,
   input  logic [15:0] dm_wdata,
   output logic        stall,
   output logic [15:0] pm_rdata,
   output logic        pm_valid,
   output logic [15:0] dm_rdata,
   output logic        dm_valid,
   output logic        err,
   output logic        ext_cs,
   output logic        ext_we,
   output logic [15:0] ext_addr,
   output logic [15:0] ext_wdata,
   input  logic [15:0] ext_rdata,
   input  logic        ext_ready
);

   fsm_t        fsm_q, fsm_d;
   logic        stall_q, stall_d;
   logic        ext_cs_q, ext_cs_d;
   logic        ext_we_q, ext_we_d;
   logic [15:0] ext_addr_q, ext_addr_d;
   logic [15:0] ext_wdata_q, ext_wdata_d;
   logic [15:0] pm_rdata_q, pm_rdata_d;
   logic [15:0] dm_rdata_q, dm_rdata_d;
   logic        pm_valid_q, pm_valid_d;
   logic        dm_valid_q, dm_valid_d;
   logic        err_q, err_d;
   logic        pm_done_q, pm_done_d;
   logic        dm_done_q, dm_done_d;

   logic pm_ext, dm_ext, in_acc, ready_ok, finish, start_dm, start_pm;
   logic min_reached, expired;

   wait_state_counter #(
      .WAIT_CYCLES (WAIT_CYCLES),
      .MAX_WAIT    (MAX_WAIT)
   ) u_wait_cnt (
      .clk         (clk),
      .rst         (rst),
      .clr         (start_dm | start_pm),
      .en          (in_acc),
      .min_reached (min_reached),
      .expired     (expired)
   );

   // Next-state logic: arbitration, access completion and done-flag upkeep.
   always_comb begin
      pm_ext   = pm_req & is_ext(pm_add) & ~pm_done_q;
      dm_ext   = dm_req & is_ext(dm_add) & ~dm_done_q;
      in_acc   = (fsm_q.state == ST_DM_ACC) | (fsm_q.state == ST_PM_ACC);
      ready_ok = min_reached & ext_ready;
      finish   = in_acc & (ready_ok | expired);
      start_dm = 1'b0;
      start_pm = 1'b0;

      fsm_d       = fsm_q;
      stall_d     = stall_q;
      ext_cs_d    = ext_cs_q;
      ext_we_d    = ext_we_q;
      ext_addr_d  = ext_addr_q;
      ext_wdata_d = ext_wdata_q;
      pm_rdata_d  = pm_rdata_q;
      dm_rdata_d  = dm_rdata_q;
      pm_valid_d  = 1'b0;
      dm_valid_d  = 1'b0;
      err_d       = 1'b0;

      case (fsm_q.state)
         ST_IDLE: begin
            if (dm_ext) begin
               start_dm = 1'b1;
            end else if (pm_ext) begin
               start_pm = 1'b1;
            end
         end
         ST_DM_ACC, ST_PM_ACC: begin
            if (finish) begin
               if (fsm_q.state == ST_DM_ACC) begin
                  dm_valid_d = 1'b1;
                  // A write leaves the load-data register untouched.
                  if (!ext_we_q) begin
                     dm_rdata_d = ready_ok ? ext_rdata : TIMEOUT_DATA;
                  end
               end else begin
                  pm_valid_d = 1'b1;
                  pm_rdata_d = ready_ok ? ext_rdata : TIMEOUT_DATA;
               end
               err_d       = ~ready_ok;
               ext_cs_d    = 1'b0;
               ext_we_d    = 1'b0;
               fsm_d.state = ST_DONE;
            end
         end
         ST_DONE: begin
            // Chain straight into the other side so the pipeline stays held.
            if (fsm_q.last_dm && pm_ext) begin
               start_pm = 1'b1;
            end else if (!fsm_q.last_dm && dm_ext) begin
               start_dm = 1'b1;
            end else begin
               stall_d     = 1'b1;
               fsm_d.state = ST_IDLE;
            end
         end
         default: fsm_d.state = ST_IDLE;
      endcase

      if (start_dm) begin
         fsm_d.state   = ST_DM_ACC;
         fsm_d.last_dm = 1'b1;
         ext_addr_d    = dm_add;
         ext_wdata_d   = dm_wdata;
         ext_we_d      = ~rwb;
         ext_cs_d      = 1'b1;
         stall_d       = 1'b0;
      end
      if (start_pm) begin
         fsm_d.state   = ST_PM_ACC;
         fsm_d.last_dm = 1'b0;
         ext_addr_d    = pm_add;
         ext_we_d      = 1'b0;
         ext_cs_d      = 1'b1;
         stall_d       = 1'b0;
      end

      // A done flag blocks re-service of a held request until it drops.
      pm_done_d = pm_req & (pm_done_q | (finish & (fsm_q.state == ST_PM_ACC)));
      dm_done_d = dm_req & (dm_done_q | (finish & (fsm_q.state == ST_DM_ACC)));
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_q       <= '{state: ST_IDLE, last_dm: 1'b0};
         stall_q     <= 1'b1;
         ext_cs_q    <= 1'b0;
         ext_we_q    <= 1'b0;
         ext_addr_q  <= '0;
         ext_wdata_q <= '0;
         pm_rdata_q  <= '0;
         dm_rdata_q  <= '0;
         pm_valid_q  <= 1'b0;
         dm_valid_q  <= 1'b0;
         err_q       <= 1'b0;
         pm_done_q   <= 1'b0;
         dm_done_q   <= 1'b0;
      end else begin
         fsm_q       <= fsm_d;
         stall_q     <= stall_d;
         ext_cs_q    <= ext_cs_d;
         ext_we_q    <= ext_we_d;
         ext_addr_q  <= ext_addr_d;
         ext_wdata_q <= ext_wdata_d;
         pm_rdata_q  <= pm_rdata_d;
         dm_rdata_q  <= dm_rdata_d;
         pm_valid_q  <= pm_valid_d;
         dm_valid_q  <= dm_valid_d;
         err_q       <= err_d;
         pm_done_q   <= pm_done_d;
         dm_done_q   <= dm_done_d;
      end
   end

   assign stall     = stall_q;
   assign ext_cs    = ext_cs_q;
   assign ext_we    = ext_we_q;
   assign ext_addr  = ext_addr_q;
   assign ext_wdata = ext_wdata_q;
   assign pm_rdata  = pm_rdata_q;
   assign dm_rdata  = dm_rdata_q;
   assign pm_valid  = pm_valid_q;
   assign dm_valid  = dm_valid_q;
   assign err       = err_q;

endmodule
